// File: rtl/dispatch_if.sv
// Rename-to-dispatch and dispatch-to-reservation-station signal bundle.
// slave is the dispatch unit's view, master is the rename/RS side.
interface dispatch_if;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_physical_rd;
   logic [5:0]  in_physical_rs1;
   logic [5:0]  in_physical_rs2;
   logic        in_rs1_ready;
   logic        in_rs2_ready;
   logic [31:0] in_rs1_value;
   logic [31:0] in_rs2_value;
   logic [3:0]  in_ALUControl;
   logic [31:0] in_imm;
   logic        in_LoadStore;
   logic        in_ALUSrc;
   logic        in_RegWrite;
   logic        in_BMS;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic [1:0]  rs_release_count;
   logic [1:0]  rob_retire_count;
   logic        flush;
   logic [5:0]  flush_rob_tail;
   logic        disp_valid;
   logic [5:0]  physical_rd;
   logic [5:0]  physical_rs1;
   logic [5:0]  physical_rs2;
   logic        rs1_ready;
   logic        rs2_ready;
   logic [31:0] rs1_value;
   logic [31:0] rs2_value;
   logic [5:0]  ROB_num;
   logic [3:0]  ALUControl;
   logic [31:0] imm;
   logic        LoadStore;
   logic        ALUSrc;
   logic        RegWrite;
   logic        BMS;
   logic [1:0]  FU_num;
   logic [6:0]  rs_credit;
   logic [6:0]  rob_count;
   logic        credit_err;

   modport slave (
      input  in_valid, in_physical_rd, in_physical_rs1, in_physical_rs2,
             in_rs1_ready, in_rs2_ready, in_rs1_value, in_rs2_value,
             in_ALUControl, in_imm, in_LoadStore, in_ALUSrc, in_RegWrite, in_BMS,
             cdb_valid, cdb_tag, cdb_value, rs_release_count, rob_retire_count,
             flush, flush_rob_tail,
      output in_ready, disp_valid, physical_rd, physical_rs1, physical_rs2,
             rs1_ready, rs2_ready, rs1_value, rs2_value, ROB_num, ALUControl, imm,
             LoadStore, ALUSrc, RegWrite, BMS, FU_num, rs_credit, rob_count, credit_err
   );

   modport master (
      output in_valid, in_physical_rd, in_physical_rs1, in_physical_rs2,
             in_rs1_ready, in_rs2_ready, in_rs1_value, in_rs2_value,
             in_ALUControl, in_imm, in_LoadStore, in_ALUSrc, in_RegWrite, in_BMS,
             cdb_valid, cdb_tag, cdb_value, rs_release_count, rob_retire_count,
             flush, flush_rob_tail,
      input  in_ready, disp_valid, physical_rd, physical_rs1, physical_rs2,
             rs1_ready, rs2_ready, rs1_value, rs2_value, ROB_num, ALUControl, imm,
             LoadStore, ALUSrc, RegWrite, BMS, FU_num, rs_credit, rob_count, credit_err
   );
endinterface

// File: rtl/dispatch_unit.sv
// Dispatch stage: ROB/FU assignment, RS/ROB credit tracking and same-cycle CDB forward
// into a registered one-cycle reservation-station write.
module dispatch_unit #(
   parameter int RS_SIZE    = 64,
   parameter int ROB_SIZE   = 64,
   parameter int NUM_ALU_FU = 3
) (
   input  logic     clk,
   input  logic     reset,
   dispatch_if.slave bus
);
   localparam logic signed [8:0] RS_MAX  = 9'(RS_SIZE);
   localparam logic signed [8:0] ROB_MAX = 9'(ROB_SIZE);
   localparam logic [1:0]        LS_FU   = 2'd2;
   localparam logic [1:0]        RR_LAST = 2'(NUM_ALU_FU - 1);

   logic        r_disp_valid;
   logic [5:0]  r_physical_rd, r_physical_rs1, r_physical_rs2;
   logic        r_rs1_ready, r_rs2_ready;
   logic [31:0] r_rs1_value, r_rs2_value;
   logic [5:0]  r_rob_num;
   logic [3:0]  r_alu_control;
   logic [31:0] r_imm;
   logic        r_load_store, r_alu_src, r_reg_write, r_bms;
   logic [1:0]  r_fu_num;
   logic [5:0]  r_rob_tail;
   logic [1:0]  r_rr_ptr;
   logic [6:0]  r_rs_credit, r_rob_count;
   logic        r_credit_err;

   logic               w_in_ready, w_accept, w_ovf;
   logic [32:0]        w_rs1_fwd, w_rs2_fwd;
   logic [1:0]         w_fu_num;
   logic signed [8:0]  w_rs_sum, w_rob_sum;
   logic [6:0]         w_rs_next, w_rob_next;

   // {ready, value}: tag 0 is the hardwired zero register, else snoop the CDB
   function automatic logic [32:0] fwd(input logic [5:0] tag, input logic rdy,
                                       input logic [31:0] val, input logic cv,
                                       input logic [5:0] ct, input logic [31:0] cval);
      logic [32:0] res;
      res = {rdy, val};
      if (tag == 6'd0)
         res = {1'b1, 32'd0};
      else if (!rdy && cv && (ct == tag))
         res = {1'b1, cval};
      return res;
   endfunction

   always_comb begin
      w_in_ready = !reset && !bus.flush && (r_rs_credit != 7'd0)
                   && (r_rob_count != 7'(ROB_SIZE));
      w_accept   = bus.in_valid && w_in_ready;
      w_rs1_fwd  = fwd(bus.in_physical_rs1, bus.in_rs1_ready, bus.in_rs1_value,
                       bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
      w_rs2_fwd  = fwd(bus.in_physical_rs2, bus.in_rs2_ready, bus.in_rs2_value,
                       bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
      w_fu_num   = bus.in_LoadStore ? LS_FU : r_rr_ptr;
   end

   // Credit arithmetic in 9-bit signed so both over- and under-flow are visible
   always_comb begin
      w_rs_sum  = $signed({2'b00, r_rs_credit}) - $signed({8'd0, w_accept})
                  + $signed({7'd0, bus.rs_release_count});
      w_rob_sum = $signed({2'b00, r_rob_count}) + $signed({8'd0, w_accept})
                  - $signed({7'd0, bus.rob_retire_count});
      w_ovf      = 1'b0;
      w_rs_next  = w_rs_sum[6:0];
      w_rob_next = w_rob_sum[6:0];
      if (w_rs_sum > RS_MAX) begin
         w_rs_next = 7'(RS_SIZE);
         w_ovf     = 1'b1;
      end else if (w_rs_sum[8]) begin
         w_rs_next = 7'd0;
         w_ovf     = 1'b1;
      end
      if (w_rob_sum > ROB_MAX) begin
         w_rob_next = 7'(ROB_SIZE);
         w_ovf      = 1'b1;
      end else if (w_rob_sum[8]) begin
         w_rob_next = 7'd0;
         w_ovf      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_disp_valid   <= 1'b0;
         r_physical_rd  <= '0;
         r_physical_rs1 <= '0;
         r_physical_rs2 <= '0;
         r_rs1_ready    <= 1'b0;
         r_rs2_ready    <= 1'b0;
         r_rs1_value    <= '0;
         r_rs2_value    <= '0;
         r_rob_num      <= '0;
         r_alu_control  <= '0;
         r_imm          <= '0;
         r_load_store   <= 1'b0;
         r_alu_src      <= 1'b0;
         r_reg_write    <= 1'b0;
         r_bms          <= 1'b0;
         r_fu_num       <= '0;
         r_rob_tail     <= '0;
         r_rr_ptr       <= '0;
         r_rs_credit    <= 7'(RS_SIZE);
         r_rob_count    <= '0;
         r_credit_err   <= 1'b0;
      end else if (bus.flush) begin
         r_disp_valid <= 1'b0;
         r_rob_tail   <= bus.flush_rob_tail;
         r_rr_ptr     <= '0;
         r_rob_count  <= '0;
         r_rs_credit  <= 7'(RS_SIZE);
      end else begin
         r_disp_valid <= w_accept;
         r_rs_credit  <= w_rs_next;
         r_rob_count  <= w_rob_next;
         if (w_ovf)
            r_credit_err <= 1'b1;
         if (w_accept) begin
            r_physical_rd  <= bus.in_physical_rd;
            r_physical_rs1 <= bus.in_physical_rs1;
            r_physical_rs2 <= bus.in_physical_rs2;
            r_rs1_ready    <= w_rs1_fwd[32];
            r_rs1_value    <= w_rs1_fwd[31:0];
            r_rs2_ready    <= w_rs2_fwd[32];
            r_rs2_value    <= w_rs2_fwd[31:0];
            r_alu_control  <= bus.in_ALUControl;
            r_imm          <= bus.in_imm;
            r_load_store   <= bus.in_LoadStore;
            r_alu_src      <= bus.in_ALUSrc;
            r_reg_write    <= bus.in_RegWrite;
            r_bms          <= bus.in_BMS;
            r_fu_num       <= w_fu_num;
            r_rob_num      <= r_rob_tail;
            r_rob_tail     <= r_rob_tail + 6'd1;
            if (!bus.in_LoadStore)
               r_rr_ptr <= (r_rr_ptr == RR_LAST) ? 2'd0 : r_rr_ptr + 2'd1;
         end
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.disp_valid   = r_disp_valid;
   assign bus.physical_rd  = r_physical_rd;
   assign bus.physical_rs1 = r_physical_rs1;
   assign bus.physical_rs2 = r_physical_rs2;
   assign bus.rs1_ready    = r_rs1_ready;
   assign bus.rs2_ready    = r_rs2_ready;
   assign bus.rs1_value    = r_rs1_value;
   assign bus.rs2_value    = r_rs2_value;
   assign bus.ROB_num      = r_rob_num;
   assign bus.ALUControl   = r_alu_control;
   assign bus.imm          = r_imm;
   assign bus.LoadStore    = r_load_store;
   assign bus.ALUSrc       = r_alu_src;
   assign bus.RegWrite     = r_reg_write;
   assign bus.BMS          = r_bms;
   assign bus.FU_num       = r_fu_num;
   assign bus.rs_credit    = r_rs_credit;
   assign bus.rob_count    = r_rob_count;
   assign bus.credit_err   = r_credit_err;
endmodule

// File: tb/tb_dispatch_unit.sv
// Bench for dispatch_unit: directed vector table, hand sequences for the credit/flush
// corners, then randomized traffic against a transaction-level reference model.
module tb_dispatch_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dispatch_if bus();
   dispatch_unit #(.RS_SIZE(64), .ROB_SIZE(64), .NUM_ALU_FU(3))
      dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int failures = 0;

   // reference model state
   int           m_credit = 64, m_count = 0, m_tail = 0, m_rr = 0;
   bit           m_err = 1'b0;
   bit           e_dv = 1'b0;
   int           e_rob = 0, e_fu = 0;
   logic [123:0] e_pay = '0;

   typedef struct {
      logic v; logic [5:0] rd, rs1, rs2; logic r1; logic [31:0] v1; logic r2; logic [31:0] v2;
      logic ls; logic cv; logic [5:0] ct; logic [31:0] cval; logic [1:0] rel, ret;
      logic xdv; logic [5:0] xrob; logic [1:0] xfu; logic [6:0] xcr, xcnt;
      logic xr1; logic [31:0] xv1; logic xr2; logic [31:0] xv2;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [32:0] m_fwd(input logic [5:0] tag, input logic rdy, input logic [31:0] val);
      if (tag == 6'd0) return {1'b1, 32'd0};
      if (!rdy && bus.cdb_valid && bus.cdb_tag == tag) return {1'b1, bus.cdb_value};
      return {rdy, val};
   endfunction

   function automatic logic [123:0] dut_pay();
      return {bus.physical_rd, bus.physical_rs1, bus.physical_rs2, bus.rs1_ready, bus.rs2_ready,
              bus.rs1_value, bus.rs2_value, bus.ALUControl, bus.imm,
              bus.LoadStore, bus.ALUSrc, bus.RegWrite, bus.BMS};
   endfunction

   task automatic model_step();
      logic [32:0] f1, f2;
      bit acc;
      int c, n;
      if (reset) begin
         m_credit = 64; m_count = 0; m_tail = 0; m_rr = 0; m_err = 1'b0;
         e_dv = 1'b0; e_rob = 0; e_fu = 0; e_pay = '0;
      end else if (bus.flush) begin
         e_dv = 1'b0; m_tail = int'(bus.flush_rob_tail); m_rr = 0; m_count = 0; m_credit = 64;
      end else begin
         acc  = bus.in_valid && m_credit > 0 && m_count < 64;
         e_dv = acc;
         if (acc) begin
            f1 = m_fwd(bus.in_physical_rs1, bus.in_rs1_ready, bus.in_rs1_value);
            f2 = m_fwd(bus.in_physical_rs2, bus.in_rs2_ready, bus.in_rs2_value);
            e_pay = {bus.in_physical_rd, bus.in_physical_rs1, bus.in_physical_rs2, f1[32], f2[32],
                     f1[31:0], f2[31:0], bus.in_ALUControl, bus.in_imm,
                     bus.in_LoadStore, bus.in_ALUSrc, bus.in_RegWrite, bus.in_BMS};
            e_rob  = m_tail;
            m_tail = (m_tail + 1) % 64;
            if (bus.in_LoadStore) e_fu = 2;
            else begin
               e_fu = m_rr;
               m_rr = (m_rr + 1) % 3;
            end
         end
         c = m_credit - int'(acc) + int'(bus.rs_release_count);
         n = m_count + int'(acc) - int'(bus.rob_retire_count);
         if (c > 64) begin c = 64; m_err = 1'b1; end
         else if (c < 0) begin c = 0; m_err = 1'b1; end
         if (n > 64) begin n = 64; m_err = 1'b1; end
         else if (n < 0) begin n = 0; m_err = 1'b1; end
         m_credit = c;
         m_count  = n;
      end
   endtask

   // inputs are already driven; checks in_ready, advances one clock, checks registered outputs
   task automatic cycle();
      bit er;
      #1;
      er = !reset && !bus.flush && m_credit != 0 && m_count != 64;
      chk("in_ready", 128'(bus.in_ready), 128'(er));
      model_step();
      @(posedge clk);
      #1;
      chk("disp_valid", 128'(bus.disp_valid), 128'(e_dv));
      chk("ROB_num",    128'(bus.ROB_num),    128'(e_rob));
      chk("FU_num",     128'(bus.FU_num),     128'(e_fu));
      chk("rs_credit",  128'(bus.rs_credit),  128'(m_credit));
      chk("rob_count",  128'(bus.rob_count),  128'(m_count));
      chk("credit_err", 128'(bus.credit_err), 128'(m_err));
      chk("payload",    128'(dut_pay()),      128'(e_pay));
   endtask

   task automatic idle();
      bus.in_valid = 0; bus.in_physical_rd = 0; bus.in_physical_rs1 = 0; bus.in_physical_rs2 = 0;
      bus.in_rs1_ready = 0; bus.in_rs2_ready = 0; bus.in_rs1_value = 0; bus.in_rs2_value = 0;
      bus.in_ALUControl = 0; bus.in_imm = 0; bus.in_LoadStore = 0; bus.in_ALUSrc = 0;
      bus.in_RegWrite = 0; bus.in_BMS = 0; bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0;
      bus.rs_release_count = 0; bus.rob_retire_count = 0; bus.flush = 0; bus.flush_rob_tail = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   task automatic simple_op(input logic ls);
      bus.in_valid = 1; bus.in_LoadStore = ls;
      bus.in_physical_rd = 6'($urandom_range(1, 63));
      bus.in_physical_rs1 = 6'($urandom_range(1, 63)); bus.in_rs1_ready = 1;
      bus.in_physical_rs2 = 6'($urandom_range(1, 63)); bus.in_rs2_ready = 1;
      bus.in_rs1_value = $urandom; bus.in_rs2_value = $urandom; bus.in_imm = $urandom;
   endtask

   initial begin
      int prev_rob;
      bit wrap_seen;
      tbl[0] = '{1, 5, 3, 4, 1, 7, 1, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 63, 1, 1, 7, 1, 9};
      tbl[1] = '{1, 6, 1, 2, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 1, 62, 2, 1, 1, 1, 2};
      tbl[2] = '{1, 7, 1, 2, 1, 3, 1, 4, 0, 0, 0, 0, 0, 0, 1, 2, 2, 61, 3, 1, 3, 1, 4};
      tbl[3] = '{1, 8, 1, 2, 1, 5, 1, 6, 0, 0, 0, 0, 0, 0, 1, 3, 0, 60, 4, 1, 5, 1, 6};
      tbl[4] = '{1, 9, 1, 2, 1, 8, 1, 9, 1, 0, 0, 0, 0, 0, 1, 4, 2, 59, 5, 1, 8, 1, 9};
      tbl[5] = '{1, 10, 12, 0, 0, 0, 0, 55, 0, 1, 12, 32'hDEADBEEF, 0, 0, 1, 5, 1, 58, 6, 1, 32'hDEADBEEF, 1, 0};
      tbl[6] = '{1, 11, 12, 4, 0, 77, 0, 3, 0, 1, 13, 32'h1234, 0, 0, 1, 6, 2, 57, 7, 0, 77, 0, 3};
      tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 6, 2, 60, 6, 0, 77, 0, 3};

      // directed vector table
      do_reset();
      for (int i = 0; i < 8; i++) begin
         idle();
         bus.in_valid = tbl[i].v; bus.in_physical_rd = tbl[i].rd;
         bus.in_physical_rs1 = tbl[i].rs1; bus.in_physical_rs2 = tbl[i].rs2;
         bus.in_rs1_ready = tbl[i].r1; bus.in_rs1_value = tbl[i].v1;
         bus.in_rs2_ready = tbl[i].r2; bus.in_rs2_value = tbl[i].v2;
         bus.in_LoadStore = tbl[i].ls; bus.in_ALUControl = 4'h2; bus.in_RegWrite = 1;
         bus.cdb_valid = tbl[i].cv; bus.cdb_tag = tbl[i].ct; bus.cdb_value = tbl[i].cval;
         bus.rs_release_count = tbl[i].rel; bus.rob_retire_count = tbl[i].ret;
         cycle();
         chk("vec_dv",   128'(bus.disp_valid), 128'(tbl[i].xdv));
         chk("vec_rob",  128'(bus.ROB_num),    128'(tbl[i].xrob));
         chk("vec_fu",   128'(bus.FU_num),     128'(tbl[i].xfu));
         chk("vec_cr",   128'(bus.rs_credit),  128'(tbl[i].xcr));
         chk("vec_cnt",  128'(bus.rob_count),  128'(tbl[i].xcnt));
         chk("vec_r1",   128'(bus.rs1_ready),  128'(tbl[i].xr1));
         chk("vec_v1",   128'(bus.rs1_value),  128'(tbl[i].xv1));
         chk("vec_r2",   128'(bus.rs2_ready),  128'(tbl[i].xr2));
         chk("vec_v2",   128'(bus.rs2_value),  128'(tbl[i].xv2));
      end

      // fill RS and ROB, blocked 65th, release/retire reopens, ROB_num wraps
      do_reset();
      prev_rob = -1;
      wrap_seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         idle(); simple_op(0); cycle();
         if (prev_rob == 63 && bus.ROB_num == 6'd0) wrap_seen = 1'b1;
         prev_rob = int'(bus.ROB_num);
      end
      chk("full_credit", 128'(bus.rs_credit), 128'(0));
      chk("full_ready",  128'(bus.in_ready),  128'(0));
      idle(); simple_op(0); cycle();
      chk("no_65th_dv", 128'(bus.disp_valid), 128'(0));
      idle(); bus.rs_release_count = 2; bus.rob_retire_count = 2; cycle();
      chk("reopen_credit", 128'(bus.rs_credit), 128'(2));
      idle(); #1;
      chk("reopen_ready", 128'(bus.in_ready), 128'(1));
      for (int i = 0; i < 64; i++) begin
         idle(); simple_op(0); bus.rs_release_count = 1; bus.rob_retire_count = 1; cycle();
         if (bus.disp_valid && prev_rob == 63 && bus.ROB_num == 6'd0) wrap_seen = 1'b1;
         if (bus.disp_valid) prev_rob = int'(bus.ROB_num);
      end
      chk("rob_wrap_seen", 128'(wrap_seen), 128'(1));

      // flush cancels the next write and restarts ROB at flush_rob_tail
      do_reset();
      idle(); simple_op(0); cycle();
      idle(); simple_op(0); bus.flush = 1; bus.flush_rob_tail = 6'd20; cycle();
      chk("flush_dv",     128'(bus.disp_valid), 128'(0));
      chk("flush_credit", 128'(bus.rs_credit),  128'(64));
      chk("flush_count",  128'(bus.rob_count),  128'(0));
      idle(); simple_op(0); cycle();
      chk("post_flush_rob", 128'(bus.ROB_num), 128'(20));
      chk("post_flush_fu",  128'(bus.FU_num),  128'(0));

      // credit overflow is sticky through flush, cleared by reset
      do_reset();
      idle(); simple_op(0); cycle();
      idle(); bus.rs_release_count = 3; bus.rob_retire_count = 1; cycle();
      chk("ovf_credit", 128'(bus.rs_credit),  128'(64));
      chk("ovf_err",    128'(bus.credit_err), 128'(1));
      idle(); cycle(); cycle();
      idle(); bus.flush = 1; cycle();
      chk("err_after_flush", 128'(bus.credit_err), 128'(1));
      do_reset();
      chk("err_after_reset", 128'(bus.credit_err), 128'(0));

      // randomized traffic, alternating starved and generous release phases
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 255) == 0);
         bus.flush = ($urandom_range(0, 63) == 0);
         bus.flush_rob_tail = 6'($urandom);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.in_physical_rd = 6'($urandom);
         bus.in_physical_rs1 = 6'($urandom_range(0, 15));
         bus.in_physical_rs2 = 6'($urandom_range(0, 15));
         bus.in_rs1_ready = 1'($urandom); bus.in_rs2_ready = 1'($urandom);
         bus.in_rs1_value = $urandom; bus.in_rs2_value = $urandom;
         bus.in_ALUControl = 4'($urandom); bus.in_imm = $urandom;
         bus.in_LoadStore = 1'($urandom); bus.in_ALUSrc = 1'($urandom);
         bus.in_RegWrite = 1'($urandom); bus.in_BMS = 1'($urandom);
         bus.cdb_valid = 1'($urandom); bus.cdb_tag = 6'($urandom_range(0, 15));
         bus.cdb_value = $urandom;
         if (((i / 300) % 2) == 0) begin
            bus.rs_release_count = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
            bus.rob_retire_count = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
         end else begin
            bus.rs_release_count = 2'($urandom_range(0, 3));
            bus.rob_retire_count = 2'($urandom_range(0, 3));
         end
         cycle();
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
